// File: rtl/bi_mem_fifo_pkg.sv
// Shared types and helpers for the two-port-memory FIFO controller.
package bi_mem_fifo_pkg;

    // Occupancy of the 2-entry output buffer; the encoding equals the entry count.
    typedef enum logic [1:0] {
        BUF_EMPTY = 2'd0,
        BUF_ONE   = 2'd1,
        BUF_TWO   = 2'd2
    } buf_state_t;

    // Pointer width for a memory of the given depth (at least one bit).
    function automatic int ptrW(input int height);
        return (height > 1) ? $clog2(height) : 1;
    endfunction

endpackage

// File: rtl/bi_mem_fifo_chk.sv
// Property checks for the output buffer of the FIFO controller.
module bi_mem_fifo_chk
    import bi_mem_fifo_pkg::*;
(
    input logic       clk_i,
    input logic       rst_ni,
    input logic       load_i,
    input logic       pop_i,
    input buf_state_t state_i
);

    // The read-issue throttle must never deliver a word into a full buffer.
    a_no_load_into_two: assert property (
        @(posedge clk_i) disable iff (!rst_ni)
        !(load_i && !pop_i && (state_i == BUF_TWO))
    ) else $error("load into TWO");

endmodule

// File: rtl/bi_skid_buf2.sv
// Two-entry output buffer that absorbs the registered memory read data and
// presents it as a valid/ready stream with a registered head word.
module bi_skid_buf2
    import bi_mem_fifo_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             load_i,
    input  logic [WIDTH-1:0] data_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [WIDTH-1:0] data_o,
    output logic [1:0]       count_o,
    output buf_state_t       state_o
);

    buf_state_t       state_q;
    logic [WIDTH-1:0] head_q;
    logic [WIDTH-1:0] tail_q;
    logic             pop_s;

    assign valid_o = (state_q != BUF_EMPTY);
    assign pop_s   = valid_o & ready_i;
    assign data_o  = head_q;
    assign state_o = state_q;

    // Entry count derived from the buffer state.
    always_comb begin
        count_o = 2'd0;
        case (state_q)
            BUF_EMPTY: count_o = 2'd0;
            BUF_ONE:   count_o = 2'd1;
            BUF_TWO:   count_o = 2'd2;
            default:   count_o = 2'd0;
        endcase
    end

    // Buffer state machine: loads append, pops shift the tail into the head.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= BUF_EMPTY;
            head_q  <= {WIDTH{1'b0}};
            tail_q  <= {WIDTH{1'b0}};
        end else begin
            case (state_q)
                BUF_EMPTY: begin
                    if (load_i) begin
                        head_q  <= data_i;
                        state_q <= BUF_ONE;
                    end
                end
                BUF_ONE: begin
                    if (load_i && pop_s) begin
                        head_q <= data_i;
                    end else if (load_i) begin
                        tail_q  <= data_i;
                        state_q <= BUF_TWO;
                    end else if (pop_s) begin
                        state_q <= BUF_EMPTY;
                    end
                end
                BUF_TWO: begin
                    if (pop_s) begin
                        head_q <= tail_q;
                        // A load here cannot occur given the issue throttle;
                        // keep both words if it ever does.
                        if (load_i) begin
                            tail_q <= data_i;
                        end else begin
                            state_q <= BUF_ONE;
                        end
                    end
                end
                default: begin
                    state_q <= BUF_EMPTY;
                end
            endcase
        end
    end

endmodule

// File: rtl/bi_mem_tp_fifo_ctrl.sv
// FIFO controller for a two-port masked-write memory: pushes become memory
// writes, prefetch reads fill a 2-entry output buffer feeding the pop stream.
module bi_mem_tp_fifo_ctrl
    import bi_mem_fifo_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int HEIGHT = 16,
    parameter int MASK   = 4,
    localparam int AW    = ptrW(HEIGHT),
    localparam int LW    = $clog2(HEIGHT + 3)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             inValid_i,
    output logic             inReady_o,
    input  logic [WIDTH-1:0] inData_i,
    output logic             outValid_o,
    input  logic             outReady_i,
    output logic [WIDTH-1:0] outData_o,
    output logic [LW-1:0]    level_o,
    output logic             memWriteEnable_o,
    output logic [MASK-1:0]  memWriteMask_o,
    output logic [AW-1:0]    memWriteAddr_o,
    output logic [WIDTH-1:0] memWriteData_o,
    output logic             memReadEnable_o,
    output logic [AW-1:0]    memReadAddr_o,
    input  logic [WIDTH-1:0] memReadData_i
);

    localparam logic [AW:0] CNT_FULL = (AW + 1)'(HEIGHT);

    logic [AW-1:0] wrPtr_q, wrPtr_d;
    logic [AW-1:0] rdPtr_q, rdPtr_d;
    logic [AW:0]   memCount_q, memCount_d;
    logic          inflight_q, inflight_d;

    logic          push_s;
    logic          pop_s;
    logic          issue_s;
    logic          bufValid_s;
    logic [1:0]    bufCount_s;
    logic [2:0]    occ_s;
    logic [2:0]    limit_s;
    buf_state_t    bufState_s;

    // A full memory blocks pushes even if a read frees a slot this cycle,
    // so inReady_o depends only on registered state.
    assign inReady_o  = rst_ni & (memCount_q != CNT_FULL);
    assign push_s     = inValid_i & inReady_o;
    assign outValid_o = rst_ni & bufValid_s;
    assign pop_s      = outValid_o & outReady_i;

    // Issue a prefetch only while buffer plus in-flight read, net of this
    // cycle's pop, still leaves room for the returning word.
    assign occ_s   = {1'b0, bufCount_s} + {2'b00, inflight_q};
    assign limit_s = 3'd2 + {2'b00, pop_s};
    assign issue_s = rst_ni & (memCount_q != {(AW + 1){1'b0}}) & (occ_s < limit_s);

    assign memWriteEnable_o = push_s;
    assign memWriteMask_o   = {MASK{1'b1}};
    assign memWriteAddr_o   = wrPtr_q;
    assign memWriteData_o   = inData_i;
    assign memReadEnable_o  = issue_s;
    assign memReadAddr_o    = rdPtr_q;

    assign level_o = LW'(memCount_q) + LW'(inflight_q) + LW'(bufCount_s);

    // Next-state for pointers, committed-word count and in-flight flag.
    always_comb begin
        wrPtr_d    = wrPtr_q;
        rdPtr_d    = rdPtr_q;
        memCount_d = memCount_q + {{AW{1'b0}}, push_s} - {{AW{1'b0}}, issue_s};
        inflight_d = issue_s;
        if (push_s) begin
            wrPtr_d = wrPtr_q + {{(AW - 1){1'b0}}, 1'b1};
        end else begin
            wrPtr_d = wrPtr_q;
        end
        if (issue_s) begin
            rdPtr_d = rdPtr_q + {{(AW - 1){1'b0}}, 1'b1};
        end else begin
            rdPtr_d = rdPtr_q;
        end
    end

    // Control state registers; reset drops any pending read result.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wrPtr_q    <= {AW{1'b0}};
            rdPtr_q    <= {AW{1'b0}};
            memCount_q <= {(AW + 1){1'b0}};
            inflight_q <= 1'b0;
        end else begin
            wrPtr_q    <= wrPtr_d;
            rdPtr_q    <= rdPtr_d;
            memCount_q <= memCount_d;
            inflight_q <= inflight_d;
        end
    end

    bi_skid_buf2 #(
        .WIDTH (WIDTH)
    ) u_buf (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .load_i  (inflight_q),
        .data_i  (memReadData_i),
        .valid_o (bufValid_s),
        .ready_i (outReady_i),
        .data_o  (outData_o),
        .count_o (bufCount_s),
        .state_o (bufState_s)
    );

    bi_mem_fifo_chk u_chk (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .load_i  (inflight_q),
        .pop_i   (pop_s),
        .state_i (bufState_s)
    );

endmodule

// File: tb/tb_bi_mem_tp_fifo_ctrl.sv
// Directed bench for the FIFO controller with a behavioural 1-cycle TP memory.
module tb_bi_mem_tp_fifo_ctrl;

    localparam int WIDTH  = 16;
    localparam int HEIGHT = 16;
    localparam int MASK   = 4;
    localparam int AW     = 4;
    localparam int LW     = 5;

    logic             clk_i = 1'b0;
    logic             rst_ni = 1'b0;
    logic             inValid_i = 1'b0;
    logic             inReady_o;
    logic [WIDTH-1:0] inData_i = 16'h0000;
    logic             outValid_o;
    logic             outReady_i = 1'b0;
    logic [WIDTH-1:0] outData_o;
    logic [LW-1:0]    level_o;
    logic             memWriteEnable_o;
    logic [MASK-1:0]  memWriteMask_o;
    logic [AW-1:0]    memWriteAddr_o;
    logic [WIDTH-1:0] memWriteData_o;
    logic             memReadEnable_o;
    logic [AW-1:0]    memReadAddr_o;
    logic [WIDTH-1:0] memReadData_i;

    logic [WIDTH-1:0] mem [HEIGHT];

    int vectors    = 0;
    int miscompares = 0;
    int npops      = 0;
    logic [AW-1:0] wr_exp = 4'd0;
    logic [AW-1:0] rd_exp = 4'd0;
    logic [WIDTH-1:0] sb [$];

    bi_mem_tp_fifo_ctrl #(.WIDTH(WIDTH), .HEIGHT(HEIGHT), .MASK(MASK)) dut (
        .clk_i            (clk_i),
        .rst_ni           (rst_ni),
        .inValid_i        (inValid_i),
        .inReady_o        (inReady_o),
        .inData_i         (inData_i),
        .outValid_o       (outValid_o),
        .outReady_i       (outReady_i),
        .outData_o        (outData_o),
        .level_o          (level_o),
        .memWriteEnable_o (memWriteEnable_o),
        .memWriteMask_o   (memWriteMask_o),
        .memWriteAddr_o   (memWriteAddr_o),
        .memWriteData_o   (memWriteData_o),
        .memReadEnable_o  (memReadEnable_o),
        .memReadAddr_o    (memReadAddr_o),
        .memReadData_i    (memReadData_i)
    );

    always #5 clk_i = ~clk_i;

    // Behavioural two-port memory: masked write, registered read.
    always @(posedge clk_i) begin
        if (memWriteEnable_o) begin
            for (int b = 0; b < MASK; b++) begin
                if (memWriteMask_o[b]) mem[memWriteAddr_o][b*4 +: 4] <= memWriteData_o[b*4 +: 4];
            end
        end
        if (memReadEnable_o) memReadData_i <= mem[memReadAddr_o];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs, check handshakes and the scoreboard, advance.
    task automatic step(input logic v, input logic [WIDTH-1:0] d, input logic r, output logic acc);
        logic [WIDTH-1:0] exp_d;
        chk("level", 32'(level_o), 32'(sb.size()));
        inValid_i = v; inData_i = d; outReady_i = r;
        #1;
        acc = v & inReady_o;
        chk("wr_en", 32'(memWriteEnable_o), 32'(acc));
        if (acc) begin
            chk("wr_addr", 32'(memWriteAddr_o), 32'(wr_exp));
            chk("wr_data", 32'(memWriteData_o), 32'(d));
            chk("wr_mask", 32'(memWriteMask_o), 32'hF);
        end
        if (memReadEnable_o) begin
            chk("rd_addr", 32'(memReadAddr_o), 32'(rd_exp));
            rd_exp = rd_exp + 4'd1;
        end
        if (outValid_o && r) begin
            if (sb.size() == 0) begin
                chk("pop_unexpected", 32'(outValid_o), 32'h0);
            end else begin
                exp_d = sb.pop_front();
                chk("pop_data", 32'(outData_o), 32'(exp_d));
            end
            npops++;
        end
        if (acc) begin
            sb.push_back(d);
            wr_exp = wr_exp + 4'd1;
        end
        @(posedge clk_i); #1;
        inValid_i = 1'b0; outReady_i = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic a;
        int pushed;
        int bubbles;
        int started;
        int p0;

        // ---- Reset: outputs held low ----
        #1;
        chk("rst_inReady", 32'(inReady_o), 32'h0);
        chk("rst_memRe", 32'(memReadEnable_o), 32'h0);
        @(posedge clk_i); #1;
        @(posedge clk_i); #1;
        chk("rst_outValid", 32'(outValid_o), 32'h0);
        chk("rst_level", 32'(level_o), 32'h0);
        chk("rst_memWe", 32'(memWriteEnable_o), 32'h0);
        rst_ni = 1'b1;
        #1;
        chk("post_rst_inReady", 32'(inReady_o), 32'h1);

        // ---- Test 1: single push latency ----
        step(1'b1, 16'hA5A5, 1'b0, a);
        chk("t1_accept", 32'(a), 32'h1);
        chk("t1_re_t1", 32'(memReadEnable_o), 32'h1);
        chk("t1_raddr_t1", 32'(memReadAddr_o), 32'h0);
        chk("t1_level_t1", 32'(level_o), 32'h1);
        chk("t1_valid_t1", 32'(outValid_o), 32'h0);
        step(1'b0, 16'h0000, 1'b0, a);
        chk("t1_re_t2", 32'(memReadEnable_o), 32'h0);
        chk("t1_valid_t2", 32'(outValid_o), 32'h0);
        step(1'b0, 16'h0000, 1'b0, a);
        chk("t1_valid_t3", 32'(outValid_o), 32'h1);
        chk("t1_data_t3", 32'(outData_o), 32'hA5A5);
        step(1'b0, 16'h0000, 1'b1, a);
        chk("t1_valid_after_pop", 32'(outValid_o), 32'h0);
        chk("t1_level_after_pop", 32'(level_o), 32'h0);

        // ---- Test 2: fill to capacity, then drain in order ----
        for (int i = 0; i < 18; i++) begin
            a = 1'b0;
            for (int g = 0; g < 20 && !a; g++) step(1'b1, 16'(i), 1'b0, a);
        end
        step(1'b0, 16'h0000, 1'b0, a);
        step(1'b0, 16'h0000, 1'b0, a);
        chk("t2_full_ready", 32'(inReady_o), 32'h0);
        chk("t2_full_level", 32'(level_o), 32'd18);
        step(1'b1, 16'h00FF, 1'b0, a);
        chk("t2_full_no_accept", 32'(a), 32'h0);
        for (int g = 0; g < 60 && sb.size() > 0; g++) step(1'b0, 16'h0000, 1'b1, a);
        chk("t2_drained", 32'(sb.size()), 32'h0);

        // ---- Test 4: full FIFO with push and pop in the same cycle ----
        for (int i = 0; i < 18; i++) begin
            a = 1'b0;
            for (int g = 0; g < 20 && !a; g++) step(1'b1, 16'h0100 + 16'(i), 1'b0, a);
        end
        step(1'b0, 16'h0000, 1'b0, a);
        step(1'b0, 16'h0000, 1'b0, a);
        step(1'b1, 16'h0200, 1'b1, a);
        chk("t4_same_cycle_accept", 32'(a), 32'h0);
        chk("t4_ready_next", 32'(inReady_o), 32'h1);
        step(1'b1, 16'h0201, 1'b1, a);
        chk("t4_next_accept", 32'(a), 32'h1);
        for (int g = 0; g < 60 && sb.size() > 0; g++) step(1'b0, 16'h0000, 1'b1, a);
        chk("t4_drained", 32'(sb.size()), 32'h0);

        // ---- Test 3: streaming 100 words, no bubbles ----
        pushed = 0; bubbles = 0; started = 0; p0 = npops;
        for (int c = 0; c < 400 && (npops - p0) < 100; c++) begin
            if (started != 0 && !outValid_o) bubbles++;
            if (outValid_o) started = 1;
            step(pushed < 100, 16'h3000 + 16'(pushed), 1'b1, a);
            if (a) pushed++;
        end
        chk("t3_popped", 32'(npops - p0), 32'd100);
        chk("t3_bubbles", 32'(bubbles), 32'h0);

        // ---- Test 5: random back-pressure over 1000 words ----
        pushed = 0; p0 = npops;
        for (int c = 0; c < 8000 && (pushed < 1000 || sb.size() > 0); c++) begin
            step((pushed < 1000) && ($urandom_range(0, 3) != 0), 16'($urandom),
                 1'($urandom_range(0, 1)), a);
            if (a) pushed++;
        end
        chk("t5_pushed", 32'(pushed), 32'd1000);
        chk("t5_popped", 32'(npops - p0), 32'd1000);
        chk("t5_drained", 32'(sb.size()), 32'h0);

        // ---- Test 6: reset while a read is in flight ----
        step(1'b1, 16'h0011, 1'b0, a);
        step(1'b1, 16'h0022, 1'b0, a);
        step(1'b1, 16'h0033, 1'b0, a);
        chk("t6_pre_valid", 32'(outValid_o), 32'h1);
        chk("t6_pre_level", 32'(level_o), 32'd3);
        rst_ni = 1'b0;
        #1;
        chk("t6_rst_inReady", 32'(inReady_o), 32'h0);
        chk("t6_rst_outValid", 32'(outValid_o), 32'h0);
        @(posedge clk_i); #1;
        rst_ni = 1'b1;
        sb.delete(); wr_exp = 4'd0; rd_exp = 4'd0;
        #1;
        chk("t6_post_valid", 32'(outValid_o), 32'h0);
        chk("t6_post_level", 32'(level_o), 32'h0);
        chk("t6_post_inReady", 32'(inReady_o), 32'h1);
        step(1'b1, 16'h1234, 1'b0, a);
        for (int g = 0; g < 10 && !outValid_o; g++) step(1'b0, 16'h0000, 1'b0, a);
        chk("t6_valid", 32'(outValid_o), 32'h1);
        chk("t6_data", 32'(outData_o), 32'h1234);
        step(1'b0, 16'h0000, 1'b1, a);
        chk("t6_final_level", 32'(level_o), 32'h0);
        chk("t6_final_valid", 32'(outValid_o), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
